// File: rtl/conv_pkg.sv
// Shared definitions for the GEMM stage: FSM state encoding and
// helpers that derive the matrix dimensions and counter widths.
`default_nettype none

package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_MAC    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int calc_m(input int img_h, input int img_w);
        return img_h * img_w;
    endfunction

    function automatic int calc_k(input int filter_size, input int img_c);
        return filter_size * filter_size * img_c;
    endfunction

    function automatic int calc_n(input int out_c);
        return out_c;
    endfunction

    // Counters must be able to hold the value equal to their bound.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// Signed multiply-accumulate register with synchronous clear and enable.
// sum is the accumulator's next value, available in the same cycle.
`default_nettype none

module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [OUT_WIDTH-1:0]  sum
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [OUT_WIDTH-1:0]    acc;

    always_comb begin
        prod = a * b;
        sum  = acc + {{(OUT_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_gemm.sv
// Y = X * W over a shared memory: one MAC per cycle, one read and one
// write port. Weights for each output channel are cached in wbuf.
`default_nettype none

module conv_gemm
    import conv_pkg::*;
#(
    parameter int              IMG_C       = 1,
    parameter int              IMG_W       = 8,
    parameter int              IMG_H       = 8,
    parameter int              FILTER_SIZE = 3,
    parameter int              OUT_C       = 2,
    parameter int              DATA_WIDTH  = 8,
    parameter int              OUT_WIDTH   = 32,
    parameter int              ADDR_WIDTH  = 32,
    parameter logic [31:0]     IM2COL_BASE = 32'h2000,
    parameter logic [31:0]     WEIGHT_BASE = 32'h4000,
    parameter logic [31:0]     OUTPUT_BASE = 32'h6000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_rd,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [OUT_WIDTH-1:0]  data_wr,
    output logic                  mem_wr_en,
    output logic                  done
);

    localparam int M  = calc_m(IMG_H, IMG_W);
    localparam int K  = calc_k(FILTER_SIZE, IMG_C);
    localparam int N  = calc_n(OUT_C);
    localparam int MW = cnt_width(M);
    localparam int KW = cnt_width(K);
    localparam int NW = cnt_width(N);

    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K);
    localparam logic [KW-1:0] K_PRE  = KW'(K - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);

    function automatic logic [ADDR_WIDTH-1:0] w_addr(input logic [NW-1:0] nn,
                                                     input logic [KW-1:0] kk);
        return ADDR_WIDTH'(WEIGHT_BASE) + ADDR_WIDTH'(nn) * ADDR_WIDTH'(K) + ADDR_WIDTH'(kk);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] x_addr(input logic [KW-1:0] kk,
                                                     input logic [MW-1:0] mm);
        return ADDR_WIDTH'(IM2COL_BASE) + ADDR_WIDTH'(kk) * ADDR_WIDTH'(M) + ADDR_WIDTH'(mm);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] y_addr(input logic [NW-1:0] nn,
                                                     input logic [MW-1:0] mm);
        return ADDR_WIDTH'(OUTPUT_BASE) + ADDR_WIDTH'(nn) * ADDR_WIDTH'(M) + ADDR_WIDTH'(mm);
    endfunction

    state_t                        state;
    logic [MW-1:0]                 m;
    logic [KW-1:0]                 k;
    logic [NW-1:0]                 n;
    logic signed [DATA_WIDTH-1:0]  wbuf [K];
    logic [KW-1:0]                 widx;
    logic                          mac_clr;
    logic                          mac_en;
    logic signed [OUT_WIDTH-1:0]   mac_sum;

    // Read data lags the address by one cycle, so slot k consumes word k-1.
    always_comb begin
        widx    = (k == '0) ? '0 : k - 1'b1;
        mac_clr = (state == ST_MAC) && (k == '0);
        mac_en  = (state == ST_MAC) && (k != '0);
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOAD_W && k != '0) begin
            wbuf[widx] <= data_rd;
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     ($signed(data_rd)),
        .b     (wbuf[widx]),
        .sum   (mac_sum)
    );

    // addr_rd is loaded one step ahead so the address for count k is
    // already on the port while k is current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m         <= '0;
            k         <= '0;
            n         <= '0;
            addr_rd   <= '0;
            addr_wr   <= '0;
            data_wr   <= '0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_LOAD_W;
                        m       <= '0;
                        k       <= '0;
                        n       <= '0;
                        done    <= 1'b0;
                        addr_rd <= w_addr('0, '0);
                    end
                end
                ST_LOAD_W: begin
                    if (k == K_LAST) begin
                        state   <= ST_MAC;
                        k       <= '0;
                        addr_rd <= x_addr('0, m);
                    end else begin
                        k <= k + 1'b1;
                        if (k < K_PRE) addr_rd <= w_addr(n, k + 1'b1);
                    end
                end
                ST_MAC: begin
                    if (k == K_LAST) begin
                        state     <= ST_WRITE;
                        k         <= '0;
                        mem_wr_en <= 1'b1;
                        addr_wr   <= y_addr(n, m);
                        data_wr   <= mac_sum;
                    end else begin
                        k <= k + 1'b1;
                        if (k < K_PRE) addr_rd <= x_addr(k + 1'b1, m);
                    end
                end
                ST_WRITE: begin
                    mem_wr_en <= 1'b0;
                    if (m != M_LAST) begin
                        m       <= m + 1'b1;
                        state   <= ST_MAC;
                        addr_rd <= x_addr('0, m + 1'b1);
                    end else if (n != N_LAST) begin
                        m       <= '0;
                        n       <= n + 1'b1;
                        state   <= ST_LOAD_W;
                        addr_rd <= w_addr(n + 1'b1, '0);
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
